// File: rtl/serialize_bits_pkg.sv
// Shared constants, state encoding and helpers for serialize_bits.
// Optional feature macro: SERIALIZE_BITS_PARITY_EN (adds a trailing even-parity bit).
package serialize_bits_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned CNT_W  = 7;

  // Largest transmittable length; also the shift amount base for left-aligning.
  localparam logic [CNT_W-1:0] MaxLen = CNT_W'(DATA_W);

`ifdef SERIALIZE_BITS_PARITY_EN
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StParity = 2'd2,
    StDone   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd3
  } state_e;
`endif

  // Lengths above the data width are treated as a full-width transfer.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(DATA_W)) begin
      return MaxLen;
    end
    return len[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/serialize_bits.sv
// MSB-first serializer: sends the low L bits of a latched 64-bit value, one per cycle,
// then pulses md_end. Define SERIALIZE_BITS_PARITY_EN to append an even-parity bit.
module serialize_bits
  import serialize_bits_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              md_start,
  input  logic [DATA_W-1:0] num_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              md_end
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef SERIALIZE_BITS_PARITY_EN
  logic              par_q, par_d;
`endif

  logic [CNT_W-1:0]  len_clamped;
  logic [CNT_W-1:0]  shamt;
  logic [DATA_W-1:0] shift_load;

  // Left-align the payload so the first bit to send always sits in the MSB.
  always_comb begin
    len_clamped = clamp_len(len_in);
    shamt       = MaxLen - len_clamped;
    shift_load  = num_in << shamt;
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
`ifdef SERIALIZE_BITS_PARITY_EN
    par_d     = par_q;
`endif
    bit_out   = 1'b0;
    bit_valid = 1'b0;
    busy      = 1'b0;
    md_end    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (md_start) begin
          shift_d = shift_load;
          cnt_d   = len_clamped;
`ifdef SERIALIZE_BITS_PARITY_EN
          par_d   = 1'b0;
`endif
          state_d = (len_clamped == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        bit_out   = shift_q[DATA_W-1];
        bit_valid = 1'b1;
        busy      = 1'b1;
        shift_d   = {shift_q[DATA_W-2:0], 1'b0};
        cnt_d     = cnt_q - CNT_W'(1);
`ifdef SERIALIZE_BITS_PARITY_EN
        par_d     = par_q ^ shift_q[DATA_W-1];
        if (cnt_q == CNT_W'(1)) state_d = StParity;
`else
        if (cnt_q == CNT_W'(1)) state_d = StDone;
`endif
      end
`ifdef SERIALIZE_BITS_PARITY_EN
      StParity: begin
        bit_out   = par_q;
        bit_valid = 1'b1;
        busy      = 1'b1;
        state_d   = StDone;
      end
`endif
      StDone: begin
        busy    = 1'b1;
        md_end  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
`ifdef SERIALIZE_BITS_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
`ifdef SERIALIZE_BITS_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serialize_bits.sv
// Bench for serialize_bits: a per-cycle queue model of the expected output stream,
// plus directed transfers with hand-computed stream contents and end timing.
module tb_serialize_bits;

`ifdef SERIALIZE_BITS_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        md_start = 1'b0;
  logic [63:0] num_in = '0;
  logic [7:0]  len_in = '0;
  logic        bit_out, bit_valid, busy, md_end;

  int total = 0;
  int bad   = 0;
  bit model_en = 1'b0;

  // Each entry: {bit_out, bit_valid, busy, md_end} for one future cycle; front = now.
  logic [3:0] mq[$];

  serialize_bits dut (
    .clk      (clk),
    .rstn     (rstn),
    .md_start (md_start),
    .num_in   (num_in),
    .len_in   (len_in),
    .bit_out  (bit_out),
    .bit_valid(bit_valid),
    .busy     (busy),
    .md_end   (md_end)
  );

  always #5 clk = ~clk;

  // Model: on an accepted start, enqueue the whole expected output sequence.
  initial begin
    forever begin
      @(posedge clk);
      if (!rstn) begin
        mq.delete();
        model_en = 1'b1;
      end else if (mq.size() == 0) begin
        if (md_start) begin
          int   len;
          logic p;
          len = (int'(len_in) > 64) ? 64 : int'(len_in);
          p   = 1'b0;
          for (int k = len - 1; k >= 0; k--) begin
            mq.push_back({num_in[k], 1'b1, 1'b1, 1'b0});
            p = p ^ num_in[k];
          end
          if (PAR == 1 && len > 0) mq.push_back({p, 1'b1, 1'b1, 1'b0});
          mq.push_back(4'b0011);
        end
      end else begin
        void'(mq.pop_front());
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      logic [3:0] exp_v, act_v;
      @(negedge clk);
      if (model_en) begin
        exp_v = (mq.size() != 0) ? mq[0] : 4'b0000;
        act_v = {bit_out, bit_valid, busy, md_end};
        total++;
        if (act_v !== exp_v) begin
          bad++;
          $display("FAIL cycle t=%0t {bit,valid,busy,end} act=%b exp=%b", $time, act_v, exp_v);
        end
      end
    end
  end

  task automatic chk_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Start a transfer at the next negedge (cycle t) and record the valid bits and the
  // offset of md_end. Optional extra start pulse at offset start2_off, start pulse in
  // the DONE cycle, and reset at offset rst_off. end_off = -1 if md_end never seen.
  task automatic xfer(input logic [63:0] num, input logic [7:0] len, input int start2_off,
                      input bit start_in_done, input int rst_off,
                      output logic [127:0] bits, output int nbits, output int end_off);
    bits    = '0;
    nbits   = 0;
    end_off = -1;
    @(negedge clk);
    md_start = 1'b1;
    num_in   = num;
    len_in   = len;
    for (int off = 1; off <= 200; off++) begin
      @(negedge clk);
      md_start = (off == start2_off);
      rstn     = (off != rst_off);
      if (bit_valid) begin
        bits = {bits[126:0], bit_out};
        nbits++;
      end
      if (md_end) begin
        end_off = off;
        if (start_in_done) begin
          md_start = 1'b1;
          num_in   = {$urandom, $urandom};
          len_in   = 8'd5;
          @(negedge clk);
        end
        break;
      end
      if (rst_off > 0 && off == rst_off + 3) break;
    end
    md_start = 1'b0;
    rstn     = 1'b1;
  endtask

  initial begin
    logic [127:0] bits;
    int           nbits, end_off;
    logic [63:0]  big;

    repeat (3) @(negedge clk);
    chk_int("reset_busy", int'(busy), 0);
    chk_int("reset_valid", int'(bit_valid), 0);
    rstn = 1'b1;
    @(negedge clk);

    // Basic 0x9, len 4 -> 1,0,0,1 (+parity 0).
    xfer(64'h9, 8'd4, 0, 1'b0, 0, bits, nbits, end_off);
    chk_vec("basic_bits", bits, (PAR == 1) ? 128'b10010 : 128'b1001);
    chk_int("basic_nbits", nbits, 4 + PAR);
    chk_int("basic_end", end_off, 5 + PAR);

    // Zero length.
    xfer(64'hFF, 8'd0, 0, 1'b0, 0, bits, nbits, end_off);
    chk_int("zero_nbits", nbits, 0);
    chk_int("zero_end", end_off, 1);

    // Clamp 70 -> 64.
    big = 64'h8000_0000_0000_0001;
    xfer(big, 8'd70, 0, 1'b0, 0, bits, nbits, end_off);
    chk_vec("clamp_bits", bits, (PAR == 1) ? {63'b0, big, 1'b0} : {64'b0, big});
    chk_int("clamp_nbits", nbits, 64 + PAR);
    chk_int("clamp_end", end_off, 65 + PAR);

    // Starts during SHIFT and during DONE are ignored.
    xfer(64'h5, 8'd3, 2, 1'b1, 0, bits, nbits, end_off);
    chk_vec("ign_bits", bits, (PAR == 1) ? 128'b1010 : 128'b101);
    chk_int("ign_end", end_off, 4 + PAR);
    chk_int("ign_idle_busy", int'(busy), 0);

    // Reset at t+3 of a len 8 transfer, with a start in the same cycle.
    xfer(64'hA5, 8'd8, 3, 1'b0, 3, bits, nbits, end_off);
    chk_vec("rst_bits", bits, 128'b101);
    chk_int("rst_nbits", nbits, 3);
    chk_int("rst_no_end", end_off, -1);
    chk_int("rst_busy", int'(busy), 0);

    // Fresh transfer after reset behaves normally.
    xfer(64'h9, 8'd4, 0, 1'b0, 0, bits, nbits, end_off);
    chk_vec("post_rst_bits", bits, (PAR == 1) ? 128'b10010 : 128'b1001);
    chk_int("post_rst_end", end_off, 5 + PAR);

    // 0x7, len 3 -> 1,1,1 (+parity 1).
    xfer(64'h7, 8'd3, 0, 1'b0, 0, bits, nbits, end_off);
    chk_vec("par_bits", bits, (PAR == 1) ? 128'b1111 : 128'b111);
    chk_int("par_end", end_off, 4 + PAR);

    // Single bit, upper bits must not leak.
    xfer(64'hFFFF_FFFF_FFFF_FFFE, 8'd1, 0, 1'b0, 0, bits, nbits, end_off);
    chk_vec("len1_bits", bits, 128'b0);
    chk_int("len1_nbits", nbits, 1 + PAR);
    chk_int("len1_end", end_off, 2 + PAR);

    // len 255 clamps; len 64 exact; odd lengths with random data (model-checked).
    xfer(64'hDEAD_BEEF_0123_4567, 8'd255, 0, 1'b0, 0, bits, nbits, end_off);
    chk_int("len255_end", end_off, 65 + PAR);
    xfer(64'h0123_4567_89AB_CDEF, 8'd64, 0, 1'b0, 0, bits, nbits, end_off);
    chk_vec("len64_bits", (PAR == 1) ? bits >> 1 : bits, {64'b0, 64'h0123_4567_89AB_CDEF});
    xfer(64'h0000_00F0_0000_1234, 8'd13, 0, 1'b0, 0, bits, nbits, end_off);
    chk_vec("len13_bits", (PAR == 1) ? bits >> 1 : bits, 128'h1234);
    chk_int("len13_end", end_off, 14 + PAR);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
